// File: rtl/pulse_gen_multi.sv
// Multi-channel sequence-gated pulse generator: per-channel W-bit counters with
// free-run / saturate-in-window / one-shot / off modes and one-cycle terminal ticks.
module pulse_gen_multi #(
  parameter int CH    = 4,
  parameter int W     = 3,
  parameter int SEQ_W = 6,
  parameter int NSTOP = 2
) (
  input  logic                   clk_in,
  input  logic                   rst,
  input  logic                   btn,
  input  logic [CH-1:0]          ch_sel,
  input  logic [SEQ_W-1:0]       seq,
  input  logic [NSTOP*SEQ_W-1:0] stops,
  input  logic [NSTOP-1:0]       stop_en,
  input  logic [2*CH-1:0]        mode,
  output logic [CH*W-1:0]        clk_outs,
  output logic [CH-1:0]          sat,
  output logic [CH-1:0]          tick
);

  typedef enum logic [1:0] {
    MODE_FREE    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_OFF     = 2'b11
  } mode_t;

  logic [NSTOP-1:0] stop_hit;
  logic             in_stop;

  genvar gi;
  generate
    for (gi = 0; gi < NSTOP; gi++) begin : g_stop
      assign stop_hit[gi] = stop_en[gi] && (stops[gi*SEQ_W +: SEQ_W] == seq);
    end
  endgenerate

  // One shared window decode feeds every channel.
  assign in_stop = |stop_hit;

  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      mode_t          ch_mode;
      logic [W-1:0]   cnt_reg;
      logic [W-1:0]   cnt_next;
      logic [W-1:0]   cnt_inc;
      logic           tick_reg;
      logic           tick_next;
      logic           cnt_full;
      logic           clr;

      assign ch_mode  = mode_t'(mode[2*gi +: 2]);
      assign cnt_full = &cnt_reg;
      assign cnt_inc  = cnt_reg + W'(1);
      // Restart needs the window, except in one-shot where it re-arms anywhere.
      assign clr      = btn && ch_sel[gi] && (in_stop || (ch_mode == MODE_ONESHOT));

      always_comb begin
        cnt_next = cnt_reg;
        if (ch_mode == MODE_OFF) begin
          cnt_next = '0;
        end else if (clr) begin
          cnt_next = '0;
        end else begin
          case (ch_mode)
            MODE_FREE:    cnt_next = cnt_inc;
            MODE_SAT:     cnt_next = (in_stop && cnt_full) ? cnt_reg : cnt_inc;
            MODE_ONESHOT: cnt_next = cnt_full ? cnt_reg : cnt_inc;
            default:      cnt_next = '0;
          endcase
        end
      end

      // Tick only on arrival at all-ones, never while holding there.
      assign tick_next = (&cnt_next) && !cnt_full;

      always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
          cnt_reg  <= '0;
          tick_reg <= 1'b0;
        end else begin
          cnt_reg  <= cnt_next;
          tick_reg <= tick_next;
        end
      end

      assign clk_outs[gi*W +: W] = cnt_reg;
      assign sat[gi]             = cnt_full;
      assign tick[gi]            = tick_reg;
    end
  endgenerate

endmodule

// File: tb/tb_pulse_gen_multi.sv
// Directed and randomized checks of pulse_gen_multi against an integer reference model.
module tb_pulse_gen_multi;
  localparam int CH = 4, W = 3, SEQ_W = 6, NSTOP = 2;
  localparam int TOP = (1 << W) - 1;

  logic                   clk_in = 1'b0;
  logic                   rst;
  logic                   btn;
  logic [CH-1:0]          ch_sel;
  logic [SEQ_W-1:0]       seq;
  logic [NSTOP*SEQ_W-1:0] stops;
  logic [NSTOP-1:0]       stop_en;
  logic [2*CH-1:0]        mode;
  logic [CH*W-1:0]        clk_outs;
  logic [CH-1:0]          sat;
  logic [CH-1:0]          tick;

  int pass_cnt = 0;
  int total_cnt = 0;
  int exp_cnt [CH];
  logic [CH-1:0] exp_tick;

  pulse_gen_multi #(.CH(CH), .W(W), .SEQ_W(SEQ_W), .NSTOP(NSTOP)) dut (
    .clk_in(clk_in), .rst(rst), .btn(btn), .ch_sel(ch_sel), .seq(seq),
    .stops(stops), .stop_en(stop_en), .mode(mode),
    .clk_outs(clk_outs), .sat(sat), .tick(tick)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    logic [CH*W-1:0] e_outs;
    logic [CH-1:0]   e_sat;
    for (int i = 0; i < CH; i++) begin
      e_outs[i*W +: W] = exp_cnt[i][W-1:0];
      e_sat[i]         = (exp_cnt[i] == TOP);
    end
    check({tag, ".clk_outs"}, 32'(clk_outs), 32'(e_outs));
    check({tag, ".sat"},      32'(sat),      32'(e_sat));
    check({tag, ".tick"},     32'(tick),     32'(exp_tick));
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) exp_cnt[i] = 0;
    exp_tick = '0;
  endtask

  // One clock: advance the model from the current inputs, then compare after the edge.
  task automatic step(input string tag);
    bit win = 0;
    int m, c, n;
    for (int k = 0; k < NSTOP; k++)
      if (stop_en[k] && stops[k*SEQ_W +: SEQ_W] == seq) win = 1;
    for (int i = 0; i < CH; i++) begin
      m = int'(mode[2*i +: 2]);
      c = exp_cnt[i];
      if (m == 3)                                   n = 0;
      else if (btn && ch_sel[i] && (win || m == 2)) n = 0;
      else if (m == 0)                              n = (c + 1) % (TOP + 1);
      else if (m == 1)                              n = (win && c == TOP) ? TOP : (c + 1) % (TOP + 1);
      else                                          n = (c == TOP) ? TOP : c + 1;
      exp_tick[i] = (n == TOP) && (c != TOP);
      exp_cnt[i]  = n;
    end
    @(posedge clk_in);
    #1;
    check_all(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int j = 0; j < n; j++) step(tag);
  endtask

  // Called just after an edge: pulse rst between edges and check the immediate clear.
  task automatic async_reset(input string tag);
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #2 rst = 1'b0;
  endtask

  initial begin
    int guard;
    rst = 1'b1; btn = 1'b0; ch_sel = '0; seq = '0;
    stops = {6'd45, 6'd20}; stop_en = 2'b11; mode = '0;
    model_reset();
    @(posedge clk_in); @(posedge clk_in); #1;
    check_all("reset");
    rst = 1'b0;

    steps("free_pre", 5);
    async_reset("mid_reset");
    steps("free", 17);

    // SAT window on ch1
    mode[3:2] = 2'b01; seq = 6'd20;
    steps("sat_hold", 10);
    check("sat_ch1_val", 32'(clk_outs[5:3]), 32'(TOP));
    seq = 6'd21;
    step("sat_leave");
    stop_en = 2'b01; seq = 6'd45;
    steps("sat_gated", 10);
    stop_en = 2'b11;

    // Restart in the window
    seq = 6'd20;
    steps("sat_refill", 8);
    btn = 1'b1; ch_sel = 4'b0001;
    step("btn_other_ch");
    ch_sel = 4'b0010;
    step("btn_ch1");
    check("restart_ch1", 32'(clk_outs[5:3]), 32'(0));
    btn = 1'b0;

    // One-shot on ch2 outside any window
    seq = 6'd0; mode[5:4] = 2'b10;
    steps("oneshot", 12);
    btn = 1'b1; ch_sel = 4'b0100;
    step("oneshot_clr");
    btn = 1'b0;
    steps("oneshot_rerun", 10);

    // OFF on ch3, then back to FREE
    mode[7:6] = 2'b11;
    for (int j = 0; j < 6; j++) begin
      btn = 1'($urandom_range(0, 1)); ch_sel = 4'($urandom);
      seq = (j % 2 == 0) ? 6'd20 : 6'd45;
      step("off");
    end
    btn = 1'b0; mode[7:6] = 2'b00;
    step("off_to_free");

    // SAT holding switched to FREE wraps with no tick
    mode[3:2] = 2'b01; seq = 6'd20;
    steps("sat_hold2", 9);
    mode[3:2] = 2'b00;
    step("sat_to_free");

    // Clear coincides with arrival at all-ones
    mode[3:2] = 2'b01; seq = 6'd0;
    guard = 0;
    while (exp_cnt[1] != TOP - 1 && guard < 16) begin
      step("sat_approach");
      guard++;
    end
    check("approach_bound", 32'(guard < 16), 32'(1));
    seq = 6'd20; btn = 1'b1; ch_sel = 4'b0010;
    step("clear_vs_tick");
    check("clear_tick1", 32'(tick[1]), 32'(0));
    btn = 1'b0; seq = 6'd0;

    // Randomized traffic
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 7) == 0) mode = 8'($urandom);
      case ($urandom_range(0, 3))
        0: seq = 6'd20;
        1: seq = 6'd45;
        2: seq = 6'd21;
        default: seq = 6'($urandom);
      endcase
      if ($urandom_range(0, 15) == 0) stop_en = 2'($urandom);
      btn = ($urandom_range(0, 5) == 0);
      ch_sel = 4'($urandom);
      step("rand");
      if ($urandom_range(0, 99) == 0) async_reset("rand_reset");
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
